// File: rtl/cursor_shot_if.sv
// Bus between the mouse/VGA/game side and cursor_shot_ctl.
// shots_fired exists only when CURSOR_SHOT_COUNT_EN is defined.
interface cursor_shot_if;
  logic [11:0] xpos_raw;
  logic [11:0] ypos_raw;
  logic        left_raw;
  logic        vblnk;
  logic        game_active;
  logic        shot_ack;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        shot_req;
  logic [11:0] shot_x;
  logic [11:0] shot_y;
`ifdef CURSOR_SHOT_COUNT_EN
  logic [7:0]  shots_fired;
`endif

  modport master (
    output xpos_raw, ypos_raw, left_raw, vblnk, game_active, shot_ack,
    input  xpos, ypos, shot_req, shot_x, shot_y
`ifdef CURSOR_SHOT_COUNT_EN
    , input shots_fired
`endif
  );

  modport slave (
    input  xpos_raw, ypos_raw, left_raw, vblnk, game_active, shot_ack,
    output xpos, ypos, shot_req, shot_x, shot_y
`ifdef CURSOR_SHOT_COUNT_EN
    , output shots_fired
`endif
  );
endinterface

// File: rtl/cursor_shot_ctl.sv
// Frame-synchronous cursor latch and click-to-shot req/ack sequencer for Duck Hunt.
// Optional shot counter output enabled by defining CURSOR_SHOT_COUNT_EN.
module cursor_shot_ctl #(
  parameter logic [11:0] X_MAX           = 12'd1023,
  parameter logic [11:0] Y_MAX           = 12'd767,
  parameter int          COOLDOWN_FRAMES = 8
) (
  input  logic           clk,
  input  logic           rst,
  cursor_shot_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ARMED    = 3'd1,
    REQ      = 3'd2,
    COOLDOWN = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  localparam int          CW      = (COOLDOWN_FRAMES > 1) ? $clog2(COOLDOWN_FRAMES + 1) : 1;
  localparam logic [CW-1:0] CD_LOAD = CW'(COOLDOWN_FRAMES);

  state_t        state, state_nxt;
  logic          vblnk_d;
  logic          frame_tick;
  logic          left_meta, left_s, left_s_d;
  logic          press;
  logic [11:0]   xpos_q, ypos_q;
  logic [11:0]   shot_x_q, shot_y_q;
  logic [CW-1:0] cnt;
  logic          capture, cnt_load, cnt_dec, ack_taken;

  assign frame_tick = bus.vblnk & ~vblnk_d;
  assign press      = left_s & ~left_s_d;

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblnk_d   <= 1'b0;
      left_meta <= 1'b0;
      left_s    <= 1'b0;
      left_s_d  <= 1'b0;
    end else begin
      vblnk_d   <= bus.vblnk;
      left_meta <= bus.left_raw;
      left_s    <= left_meta;
      left_s_d  <= left_s;
    end
  end

  // Cursor is latched once per frame so the draw stage never sees a mid-frame jump.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xpos_q <= '0;
      ypos_q <= '0;
    end else if (frame_tick) begin
      xpos_q <= (bus.xpos_raw > X_MAX) ? X_MAX : bus.xpos_raw;
      ypos_q <= (bus.ypos_raw > Y_MAX) ? Y_MAX : bus.ypos_raw;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    cnt_load  = 1'b0;
    cnt_dec   = 1'b0;
    ack_taken = 1'b0;
    case (state)
      IDLE: begin
        if (bus.game_active) state_nxt = ARMED;
      end
      ARMED: begin
        if (!bus.game_active) state_nxt = IDLE;
        else if (press) begin
          capture   = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        // Losing game_active aborts the shot even if the ack arrives in the same cycle.
        if (!bus.game_active) state_nxt = IDLE;
        else if (bus.shot_ack) begin
          ack_taken = 1'b1;
          if (COOLDOWN_FRAMES == 0) state_nxt = RELEASE;
          else begin
            cnt_load  = 1'b1;
            state_nxt = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (!bus.game_active) state_nxt = IDLE;
        else if (frame_tick) begin
          cnt_dec = 1'b1;
          if (cnt <= CW'(1)) state_nxt = RELEASE;
        end
      end
      RELEASE: begin
        if (!bus.game_active) state_nxt = IDLE;
        else if (!left_s)     state_nxt = ARMED;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shot_x_q <= '0;
      shot_y_q <= '0;
      cnt      <= '0;
    end else begin
      if (capture) begin
        shot_x_q <= xpos_q;
        shot_y_q <= ypos_q;
      end
      if (cnt_load)     cnt <= CD_LOAD;
      else if (cnt_dec) cnt <= cnt - 1'b1;
    end
  end

  assign bus.xpos     = xpos_q;
  assign bus.ypos     = ypos_q;
  assign bus.shot_x   = shot_x_q;
  assign bus.shot_y   = shot_y_q;
  assign bus.shot_req = (state == REQ);

`ifdef CURSOR_SHOT_COUNT_EN
  logic       game_active_d;
  logic [7:0] shots_fired_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      game_active_d <= 1'b0;
      shots_fired_q <= '0;
    end else begin
      game_active_d <= bus.game_active;
      if (game_active_d && !bus.game_active)        shots_fired_q <= '0;
      else if (ack_taken && shots_fired_q != 8'hFF) shots_fired_q <= shots_fired_q + 8'd1;
    end
  end

  assign bus.shots_fired = shots_fired_q;
`endif

endmodule
